// File: rtl/clk_en_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_pkg
//  Description : Shared helpers for the clock/enable generator. Holds a
//                ceiling-log2 function, the index-width rule used for the
//                debug counters, and the ratio defaults of the reference
//                board (50 MHz in, 25 MHz sys_clk, 4x sample, 4x symbol).
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_en_pkg;

    // Reference board configuration
    localparam int c_DEF_SYS_DIV   = 2;
    localparam int c_DEF_SAM_RATIO = 4;
    localparam int c_DEF_SYM_RATIO = 4;
    localparam int c_DEF_PH_W      = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a counter holding 0..n-1. A ratio of 1 still needs one bit
    // so that the port exists; the counter then simply stays at 0.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mod_cnt
//  Description : Modulo-N up-counter with enable and restart.
//                clr restarts the count from 0 in the same cycle: if en is
//                also high the counter steps from 0 (lands on 1), otherwise
//                it loads 0. wrap flags that this step goes N-1 -> 0.
//  Ports       : clk   - clock
//                reset - synchronous active-low reset
//                en    - advance one step
//                clr   - treat the current value as 0 for this cycle
//                cnt   - current count
//                wrap  - this enabled step wraps to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_cnt #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] c_LAST = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_base;

    assign w_base = clr ? '0 : r_cnt;
    assign wrap   = en & (w_base == c_LAST);
    assign cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap ? '0 : (w_base + W'(1));
        end else if (clr) begin
            r_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_gen
//  Description : Parametrised clock/enable generator. Divides clk into a
//                50 % duty sys_clk and produces sample, half-rate and symbol
//                enables, each one sys_clk period wide and centred on a
//                sys_clk rising edge. Supports run/hold and realignment of
//                the sample/symbol counters without disturbing sys_clk.
//  Ports       : clk         - board clock (only clock)
//                reset       - synchronous active-low reset
//                run         - 1 = counters advance, 0 = hold (enables low)
//                resync      - one-clk pulse, realign sample/symbol counters
//                sym_phase   - sample index in a symbol where sym_clk_en fires
//                sys_clk     - divided clock
//                sys_clk2_en - every second sys_clk period
//                sam_clk_en  - one sys_clk period per sample
//                sym_clk_en  - one sys_clk period per symbol
//                sam_idx     - sys_clk index within the sample (debug)
//                sym_idx     - sample index within the symbol (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int SYS_DIV   = c_DEF_SYS_DIV,
    parameter int SAM_RATIO = c_DEF_SAM_RATIO,
    parameter int SYM_RATIO = c_DEF_SYM_RATIO,
    parameter int PH_W      = c_DEF_PH_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           resync,
    input  logic [PH_W-1:0]                sym_phase,
    output logic                           sys_clk,
    output logic                           sys_clk2_en,
    output logic                           sam_clk_en,
    output logic                           sym_clk_en,
    output logic [idx_w(SAM_RATIO)-1:0]    sam_idx,
    output logic [idx_w(SYM_RATIO)-1:0]    sym_idx
);

    localparam int c_DIV_W = idx_w(SYS_DIV);
    localparam int c_SAM_W = idx_w(SAM_RATIO);
    localparam int c_SYM_W = idx_w(SYM_RATIO);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SYS_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_MID  = c_DIV_W'(SYS_DIV / 2 - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_sys_clk;
    logic               r_half;
    logic               r_pending;
    logic [PH_W-1:0]    r_phase_q;
    logic               r_sys_clk2_en;
    logic               r_sam_en;
    logic               r_sym_en;

    logic               w_strobe;
    logic               w_realign;
    logic [PH_W-1:0]    w_phase_eff;
    logic               w_sam_zero;
    logic               w_sym_match;
    logic               w_half_eff;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               w_sam_wrap;
    logic               w_sym_wrap_unused;

    // Strobe sits on the sys_clk falling edge, so everything driven from it
    // is stable around the following sys_clk rising edge.
    assign w_strobe = (r_div_cnt == c_DIV_MID);

    // A resync arriving on the strobe cycle itself acts immediately rather
    // than waiting a whole extra sys_clk period.
    assign w_realign   = r_pending | resync;
    assign w_phase_eff = resync ? sym_phase : r_phase_q;

    // During a realign the enables are evaluated as if both indices were 0
    // and half were 1.
    assign w_sam_zero  = w_realign | (sam_idx == '0);
    assign w_sym_match = w_realign ? (w_phase_eff == '0)
                                   : (32'(sym_idx) == 32'(w_phase_eff));
    assign w_half_eff  = w_realign | r_half;

    // Counters also step on a held realign so they land on their
    // post-realign values.
    assign w_cnt_en  = w_strobe & (run | w_realign);
    assign w_cnt_clr = w_strobe & w_realign;

    mod_cnt #(
        .N (SAM_RATIO),
        .W (c_SAM_W)
    ) u_sam_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en),
        .clr   (w_cnt_clr),
        .cnt   (sam_idx),
        .wrap  (w_sam_wrap)
    );

    mod_cnt #(
        .N (SYM_RATIO),
        .W (c_SYM_W)
    ) u_sym_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_sam_wrap),
        .clr   (w_cnt_clr),
        .cnt   (sym_idx),
        .wrap  (w_sym_wrap_unused)
    );

    // Divider and sys_clk: free-running, untouched by run/resync
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_sys_clk <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : (r_div_cnt + c_DIV_W'(1));
            if (r_div_cnt == c_DIV_LAST) begin
                r_sys_clk <= 1'b1;
            end else if (r_div_cnt == c_DIV_MID) begin
                r_sys_clk <= 1'b0;
            end
        end
    end

    // Enables, half-rate toggle, resync bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_half        <= 1'b1;
            r_pending     <= 1'b0;
            r_phase_q     <= sym_phase;
            r_sys_clk2_en <= 1'b0;
            r_sam_en      <= 1'b0;
            r_sym_en      <= 1'b0;
        end else begin
            if (resync) begin
                r_phase_q <= sym_phase;
            end

            if (w_strobe) begin
                r_pending <= 1'b0;
            end else if (resync) begin
                r_pending <= 1'b1;
            end

            if (w_strobe) begin
                if (run) begin
                    r_sam_en      <= w_sam_zero;
                    r_sys_clk2_en <= w_half_eff;
                    r_sym_en      <= w_sam_zero & w_sym_match;
                end else begin
                    r_sam_en      <= 1'b0;
                    r_sys_clk2_en <= 1'b0;
                    r_sym_en      <= 1'b0;
                end
                if (run | w_realign) begin
                    r_half <= ~w_half_eff;
                end
            end
        end
    end

    assign sys_clk     = r_sys_clk;
    assign sys_clk2_en = r_sys_clk2_en;
    assign sam_clk_en  = r_sam_en;
    assign sym_clk_en  = r_sym_en;

endmodule
`default_nettype wire

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised clock/enable generator, the successor to the fixed `clk_en` block. From the 50 MHz board clock it derives `sys_clk` and the sample, half-rate and symbol clock enables consumed by the filter chain (`DUT`, halfband and cascade stages). Divide ratios are parameters, and the symbol phase is runtime-selectable. It adds run/hold and resynchronisation controls so benches and the upsampler/downsampler chain can realign without a full reset.

## Interface
- `SYS_DIV`, 2: `clk` cycles per `sys_clk` period; even, ≥2.
- `SAM_RATIO`, 4: `sys_clk` periods per sample; ≥1.
- `SYM_RATIO`, 4: samples per symbol; ≥1.
- `PH_W`, 4: width of `sym_phase`; 2^PH_W ≥ SYM_RATIO.

- `clk`  in  1  board clock; the only clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `run`  in  1  1 = counters advance; 0 = hold.
- `resync`  in  1  one-`clk` pulse; realign sample/symbol counters.
- `sym_phase`  in  PH_W  sample index within a symbol at which `sym_clk_en` fires.
- `sys_clk`  out  1  divided clock, 50 % duty.
- `sys_clk2_en`  out  1  every second `sys_clk` period.
- `sam_clk_en`  out  1  one `sys_clk` period per sample.
- `sym_clk_en`  out  1  one `sys_clk` period per symbol.
- `sam_idx`  out  clog2(SAM_RATIO)  current `sys_clk` index within the sample (debug).
- `sym_idx`  out  clog2(SYM_RATIO)  current sample index within the symbol (debug).

## Operation
- `div_cnt` counts 0..SYS_DIV-1 on every `clk` and wraps to 0. It runs regardless of `run`.
- `sys_clk` register:
  - set when `div_cnt`==SYS_DIV-1;
  - cleared when `div_cnt`==SYS_DIV/2-1.
- Strobe = (`div_cnt`==SYS_DIV/2-1), i.e. the `sys_clk` falling edge. All enables and index counters update only on a strobe. Each enable is therefore held for exactly SYS_DIV `clk` cycles, centred on one `sys_clk` rising edge, which keeps the generator race-free for logic clocked by `sys_clk`.
- On each strobe with `run`=1:
  - `sam_clk_en` <= (`sam_idx`==0);
  - `sys_clk2_en` <= `half`, then `half` toggles;
  - `sym_clk_en` <= (`sam_idx`==0 && `sym_idx`==`phase_q`);
  - `sam_idx` increments modulo SAM_RATIO;
  - `sym_idx` increments modulo SYM_RATIO when `sam_idx` wraps.
- On a strobe with `run`=0: all enables <= 0; `sam_idx`, `sym_idx` and `half` hold.
- `phase_q` captures `sym_phase` at reset release and on `resync`. If `sym_phase` ≥ SYM_RATIO, `sym_clk_en` never asserts; this is legal and not an error.
- `resync` is latched into a pending flag. At the next strobe the enables are computed as if `sam_idx`=`sym_idx`=0 and `half`=1, and the counters then continue from that state. `sys_clk` and `div_cnt` are never disturbed.
- If `resync` and `run`=0 coincide at a strobe, the counters and `half` load their post-realign values and the enables stay 0.

## Timing
- In reset: `div_cnt`=0, `sys_clk`=0, all enables=0, `sam_idx`=`sym_idx`=0, `half`=1, pending flag cleared.
- Reset asserted mid-operation takes effect at the next `clk` edge; outputs follow the values above with no glitch-free stretching.
- Edge n is the n-th `clk` edge with `reset`=1:
  - first strobe at edge SYS_DIV/2;
  - first `sys_clk` rise at edge SYS_DIV;
  - on that first rise, `sam_clk_en`, `sys_clk2_en` and (if `phase_q`=0) `sym_clk_en` are all 1.
- Periods: `sam_clk_en` every SAM_RATIO·SYS_DIV `clk`; `sym_clk_en` every SYM_RATIO·SAM_RATIO·SYS_DIV `clk`; `sys_clk2_en` every 2·SYS_DIV `clk`.
- Special ratios: SAM_RATIO=1 gives `sam_clk_en` constantly 1 while running; SYM_RATIO=1 gives `sym_clk_en`=`sam_clk_en` when `phase_q`=0.
- `run` and `resync` are sampled on every `clk` but act only at strobes; latency is ≤ SYS_DIV `clk` cycles.

## Structure
- Shared package `clk_en_pkg` holds:
  - a `clog2` function;
  - index-width localparam derivation;
  - default-ratio constants for the reference board configuration.
- One sub-module, `mod_cnt`, is natural: a parametrised modulo-N counter with `en`, `clr` and a `wrap` output. It is instantiated for `sam_idx` and `sym_idx`; `div_cnt` is inline.

## Test plan
- Defaults, `run`=1, `sym_phase`=0 → `sys_clk` period 40 ns. `sam_clk_en` seen at 1 of every 4 `sys_clk` rises and `sym_clk_en` at 1 of 16, with all three enables high on the first rise (edge 2).
- SYS_DIV=4, SAM_RATIO=3, SYM_RATIO=2 → `sys_clk` high for 2 `clk` and low for 2. `sam_clk_en` every 12 `clk`, `sym_clk_en` every 24 `clk`, each 4 `clk` wide and straddling a `sys_clk` rise.
- `sym_phase`=2 with defaults → `sym_clk_en` coincides with the third `sam_clk_en` of each symbol (`sym_idx`=2). `sym_phase`=7 → `sym_clk_en` never asserts over 64 samples.
- `run` dropped for 10 `sys_clk` periods mid-symbol → enables 0 throughout and `sam_idx`/`sym_idx` frozen. After `run` returns, the sequence resumes from the held indices with no skipped or duplicated enable.
- `resync` pulse at `sam_idx`=2, `sym_idx`=3 → at the next strobe `sam_clk_en`=`sym_clk_en`=`sys_clk2_en`=1, then the indices continue 1, 2, …. `sys_clk` shows no phase jump.
- `reset` driven low for one `clk` mid-stream, then high → all outputs 0 on the following edge, and the start-up sequence repeats exactly as in scenario 1.
